// File: rtl/settings_pkg.sv
// Shared widths and sizes for the convolution core and its controller.
package settings_pkg;
    localparam int DATA_SIZE      = 16;
    localparam int WINDOW_SIZE    = 8;
    localparam int FULL_SIZE      = 2*DATA_SIZE + $clog2(WINDOW_SIZE);
    localparam int FRAME_LEN_SIZE = 16;
    localparam int DRAIN_TIMEOUT  = 64;

    localparam int COEFF_IDX_W = $clog2(WINDOW_SIZE);
    localparam int RESULT_W    = FRAME_LEN_SIZE + 1;
    localparam int TMO_W       = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} ctrl_state_t;
endpackage

// File: rtl/convol_coeff_bank.sv
// Coefficient register bank written sequentially from index 0, with a wrap-around index.
module convol_coeff_bank
    import settings_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wr_en,
    input  logic [DATA_SIZE-1:0]                  wr_data,
    output logic [WINDOW_SIZE-1:0][DATA_SIZE-1:0] coeff,
    output logic                                  loaded
);
    logic [COEFF_IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coeff  <= '0;
            idx    <= '0;
            loaded <= 1'b0;
        end else if (wr_en) begin
            coeff[idx] <= wr_data;
            if (idx == COEFF_IDX_W'(WINDOW_SIZE-1)) begin
                idx    <= '0;
                loaded <= 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/convol_ctrl.sv
// Frame sequencer for the convolution core: stream samples, flush zeros, then
// wait for the full result count or a drain timeout.
module convol_ctrl
    import settings_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_SIZE-1:0]                  cfg_coeff_data,
    input  logic                                  cfg_coeff_valid,
    output logic                                  cfg_coeff_ready,
    input  logic [FRAME_LEN_SIZE-1:0]             frame_len,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  timeout_err,
    input  logic signed [DATA_SIZE-1:0]           s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic signed [DATA_SIZE-1:0]           conv_input_data,
    output logic [WINDOW_SIZE-1:0][DATA_SIZE-1:0] conv_coeff,
    output logic                                  conv_enable,
    input  logic                                  conv_output_data_valid
);
    ctrl_state_t               state;
    logic [FRAME_LEN_SIZE-1:0] frame_len_q, sample_cnt;
    logic [RESULT_W-1:0]       result_cnt, result_tgt;
    logic [COEFF_IDX_W-1:0]    flush_cnt;
    logic [TMO_W-1:0]          tmo_cnt;
    logic                      coeff_loaded, coeff_wr, start_ok, result_hit;

    // start wins over a same-cycle coefficient write; held low during reset
    assign cfg_coeff_ready = reset && (state == IDLE) && !start;
    assign s_ready         = (state == STREAM);
    assign coeff_wr        = cfg_coeff_valid && cfg_coeff_ready;
    assign start_ok        = start && coeff_loaded && (frame_len != '0);
    assign result_tgt      = {1'b0, frame_len_q} + RESULT_W'(WINDOW_SIZE-1);
    assign result_hit      = conv_output_data_valid && (state != IDLE) &&
                             (result_cnt != result_tgt);

    convol_coeff_bank u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (coeff_wr),
        .wr_data (cfg_coeff_data),
        .coeff   (conv_coeff),
        .loaded  (coeff_loaded)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            conv_input_data <= '0;
            conv_enable     <= 1'b0;
            frame_len_q     <= '0;
            sample_cnt      <= '0;
            result_cnt      <= '0;
            flush_cnt       <= '0;
            tmo_cnt         <= '0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            if (result_hit)
                result_cnt <= result_cnt + 1'b1;
            case (state)
                IDLE: begin
                    conv_enable <= 1'b0;
                    if (start_ok) begin
                        frame_len_q <= frame_len;
                        sample_cnt  <= '0;
                        result_cnt  <= '0;
                        tmo_cnt     <= '0;
                        state       <= STREAM;
                        busy        <= 1'b1;
                    end
                end
                STREAM: begin
                    conv_enable <= s_valid;
                    if (s_valid) begin
                        conv_input_data <= s_data;
                        sample_cnt      <= sample_cnt + 1'b1;
                        if ((sample_cnt + 1'b1) == frame_len_q) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    conv_input_data <= '0;
                    conv_enable     <= 1'b1;
                    flush_cnt       <= flush_cnt + 1'b1;
                    if (flush_cnt == COEFF_IDX_W'(WINDOW_SIZE-2)) begin
                        tmo_cnt <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    conv_enable <= 1'b0;
                    if (result_cnt == result_tgt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (result_hit) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_W'(DRAIN_TIMEOUT-1)) begin
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_convol_ctrl.sv
// Directed bench for convol_ctrl with a fixed-latency core model that can stop early.
module tb_convol_ctrl;
    import settings_pkg::*;

    localparam int LAT = 12;
    localparam int CW  = WINDOW_SIZE*DATA_SIZE;

    logic                                  clk = 1'b0, reset = 1'b0;
    logic [DATA_SIZE-1:0]                  cfg_coeff_data = '0;
    logic                                  cfg_coeff_valid = 1'b0, cfg_coeff_ready;
    logic [FRAME_LEN_SIZE-1:0]             frame_len = '0;
    logic                                  start = 1'b0, busy, done, timeout_err;
    logic signed [DATA_SIZE-1:0]           s_data = '0;
    logic                                  s_valid = 1'b0, s_ready;
    logic signed [DATA_SIZE-1:0]           conv_input_data;
    logic [WINDOW_SIZE-1:0][DATA_SIZE-1:0] conv_coeff;
    logic                                  conv_enable;
    logic                                  core_vld = 1'b0;

    convol_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .cfg_coeff_data         (cfg_coeff_data),
        .cfg_coeff_valid        (cfg_coeff_valid),
        .cfg_coeff_ready        (cfg_coeff_ready),
        .frame_len              (frame_len),
        .start                  (start),
        .busy                   (busy),
        .done                   (done),
        .timeout_err            (timeout_err),
        .s_data                 (s_data),
        .s_valid                (s_valid),
        .s_ready                (s_ready),
        .conv_input_data        (conv_input_data),
        .conv_coeff             (conv_coeff),
        .conv_enable            (conv_enable),
        .conv_output_data_valid (core_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // core model: one result per enable, LAT cycles later, capped at res_limit per frame
    logic [15:0] dl = '0;
    int res_sent = 0, res_limit = 1000, last_res_cyc = 0;
    always @(negedge clk) begin
        if (!busy) res_sent = 0;
        dl = {dl[14:0], conv_enable};
        if (dl[LAT-1] && res_sent < res_limit) begin
            core_vld = 1'b1;
            res_sent++;
            last_res_cyc = cyc;
        end else begin
            core_vld = 1'b0;
        end
    end

    logic mon_clr = 1'b0, coeff_moved = 1'b0;
    logic [CW-1:0] prev_coeff = '0;
    int en_cnt = 0, en_run = 0, en_max = 0, data_sum = 0;
    int done_cnt = 0, terr_cnt = 0, terr_with_done = 0, done_cyc = 0;
    always @(negedge clk) begin
        if (mon_clr) begin
            en_cnt = 0; en_run = 0; en_max = 0; data_sum = 0; coeff_moved = 1'b0;
        end else begin
            if (conv_enable) begin
                en_cnt++; en_run++;
                if (en_run > en_max) en_max = en_run;
                data_sum += int'(conv_input_data);
            end else begin
                en_run = 0;
            end
            if (busy && conv_coeff != prev_coeff) coeff_moved = 1'b1;
        end
        prev_coeff = conv_coeff;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (timeout_err) terr_cnt++;
        if (timeout_err && done) terr_with_done++;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    function automatic logic [CW-1:0] bank(input int base, input int dir);
        logic [CW-1:0] b = '0;
        for (int i = 0; i < WINDOW_SIZE; i++) b[i*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(base + dir*i);
        return b;
    endfunction

    task automatic load(input int base, input int dir);
        for (int i = 0; i < WINDOW_SIZE; i++) begin
            cfg_coeff_valid = 1'b1;
            cfg_coeff_data  = DATA_SIZE'(base + dir*i);
            step();
        end
        cfg_coeff_valid = 1'b0;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1; step(); mon_clr = 1'b0;
    endtask

    task automatic kick(input int len);
        frame_len = FRAME_LEN_SIZE'(len);
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic send(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = DATA_SIZE'(first + i); step();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        bit ok;
        int d0, t0;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_enable", conv_enable, 0);
        chk("rst_coeff", conv_coeff, 0);
        chk("rst_cfg_ready", cfg_coeff_ready, 0);
        chk("rst_s_ready", s_ready, 0);
        reset = 1'b1;
        step(2);
        chk("idle_cfg_ready", cfg_coeff_ready, 1);

        // start with no coefficients loaded is ignored
        kick(4); step(3);
        chk("noload_busy", busy, 0);
        chk("noload_done", done_cnt, 0);

        load(1, 1);
        chk("coeff_load", conv_coeff, bank(1, 1));

        kick(0); step(3);
        chk("len0_busy", busy, 0);
        chk("len0_done", done_cnt, 0);

        // frame 4, back-to-back samples
        clr_mon();
        kick(4);
        chk("f4_busy", busy, 1);
        chk("f4_s_ready", s_ready, 1);
        send(4, 1);
        chk("f4_flush_s_ready", s_ready, 0);
        wait_done(200, ok);
        chk("f4_done", ok, 1);
        chk("f4_en_cnt", en_cnt, 11);
        chk("f4_en_run", en_max, 11);
        chk("f4_data_sum", data_sum, 10);
        chk("f4_coeff_stable", coeff_moved, 0);
        chk("f4_coeff", conv_coeff, bank(1, 1));
        chk("f4_no_tmo", terr_cnt, 0);
        chk("f4_idle", busy, 0);

        // frame 3 with gapped valid; back-to-back start right after done
        clr_mon();
        kick(3);
        s_valid = 1'b1; s_data = 5;  step();
        s_valid = 1'b0; s_data = 99; step();
        s_valid = 1'b1; s_data = 6;  step();
        s_valid = 1'b0; s_data = 99; step();
        s_valid = 1'b1; s_data = 7;  step();
        s_valid = 1'b0;
        chk("f3_last_data", conv_input_data, 7);
        chk("f3_flush_s_ready", s_ready, 0);
        step();
        chk("f3_flush_zero", conv_input_data, 0);
        chk("f3_flush_en", conv_enable, 1);
        wait_done(200, ok);
        chk("f3_done", ok, 1);
        chk("f3_en_cnt", en_cnt, 10);
        chk("f3_en_run", en_max, 8);
        chk("f3_data_sum", data_sum, 18);

        // core stalls after 5 results: drain timeout
        res_limit = 5;
        t0 = terr_with_done;
        kick(4);
        send(4, 1);
        wait_done(300, ok);
        chk("tmo_done", ok, 1);
        chk("tmo_err_with_done", terr_with_done - t0, 1);
        chk("tmo_delay", done_cyc - last_res_cyc, 65);
        chk("tmo_idle", busy, 0);
        res_limit = 1000;
        step(20);

        // coefficient write and start together: start wins
        cfg_coeff_valid = 1'b1; cfg_coeff_data = 16'h55;
        frame_len = 2; start = 1'b1;
        #1;
        chk("race_cfg_ready", cfg_coeff_ready, 0);
        step();
        cfg_coeff_valid = 1'b0; start = 1'b0;
        chk("race_busy", busy, 1);
        send(2, 3);
        wait_done(200, ok);
        chk("race_done", ok, 1);
        chk("race_coeff", conv_coeff, bank(1, 1));
        cfg_coeff_valid = 1'b1; cfg_coeff_data = 16'h77; step();
        cfg_coeff_valid = 1'b0;
        chk("race_idx0", conv_coeff[0], 16'h77);

        // reset mid-stream aborts silently
        kick(6);
        send(2, 1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_enable", conv_enable, 0);
        chk("mid_rst_data", conv_input_data, 0);
        chk("mid_rst_coeff", conv_coeff, 0);
        step(3);
        reset = 1'b1;
        step(20);
        chk("mid_rst_no_done", done_cnt, d0);
        kick(2); step(2);
        chk("mid_rst_unloaded", busy, 0);
        load(8, -1);
        chk("reload_coeff", conv_coeff, bank(8, -1));
        clr_mon();
        kick(2);
        send(2, 20);
        wait_done(200, ok);
        chk("reload_done", ok, 1);
        chk("reload_en_cnt", en_cnt, 9);
        chk("reload_data_sum", data_sum, 41);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
